// File: rtl/mem_data_req_if.sv
// Sram-like data bus between the MEM-stage access controller (master) and data memory (slave).
interface mem_data_req_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_data_req.sv
// MEM-stage data access controller: one sram-like transaction per instruction, stall until response.
// Optional MEM_ADDR_EXC_EN: misaligned accesses raise mem_adel/mem_ades and are not issued.
//
// state  | meaning
// IDLE   | no transaction; issue as soon as a valid access sits in MEM
// REQ    | request presented, waiting for addr_ok
// WAIT   | request accepted, waiting for data_ok
// DONE   | result delivered; pipeline held by another cause
// CANCEL | flushed while waiting; the next data_ok is stale and dropped
module mem_data_req (
  input  logic           clk,
  input  logic           reset,
  input  logic           mem_data_en,
  input  logic [3:0]     mem_data_ren,
  input  logic [3:0]     mem_data_wen,
  input  logic [31:0]    mem_addr,
  input  logic [31:0]    mem_wdata,
  input  logic           mem_loadX,
  input  logic           mem_flush,
  input  logic           other_stall,
  mem_data_req_if.master bus,
  output logic           mem_stall,
  output logic [31:0]    mem_rdata,
  output logic           mem_adel,
  output logic           mem_ades
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t      state, state_nxt;
  logic        wr;
  logic [3:0]  mask;
  logic [2:0]  lanes;
  logic [1:0]  size;
  logic        addr_exc;
  logic        go;
  logic        latch;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign wr    = |mem_data_wen;
  assign mask  = wr ? mem_data_wen : mem_data_ren;
  assign lanes = {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};

  always_comb begin
    case (lanes)
      3'd1:    size = 2'd0;
      3'd2:    size = 2'd1;
      default: size = 2'd2;
    endcase
  end

`ifdef MEM_ADDR_EXC_EN
  assign addr_exc = ((size == 2'd2) && (mem_addr[1:0] != 2'b00)) || ((size == 2'd1) && mem_addr[0]);
  assign mem_adel = mem_data_en & addr_exc & ~wr;
  assign mem_ades = mem_data_en & addr_exc & wr;
`else
  assign addr_exc = 1'b0;
  assign mem_adel = 1'b0;
  assign mem_ades = 1'b0;
`endif

  assign go = mem_data_en & ~mem_flush & ~addr_exc;

  assign bus.data_req   = ((state == S_IDLE) & go) | (state == S_REQ);
  assign bus.data_wr    = wr;
  assign bus.data_size  = size;
  assign bus.data_addr  = mem_addr;
  assign bus.data_wstrb = mem_data_wen;
  assign bus.data_wdata = mem_wdata;

  // Stall never depends on data_ok: it drops only once the FSM has moved to DONE.
  assign mem_stall = ((state == S_IDLE) & go) | (state == S_REQ) | (state == S_WAIT) |
                     ((state == S_CANCEL) & mem_data_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      S_IDLE:   if (go) state_nxt = bus.data_addr_ok ? S_WAIT : S_REQ;
      S_REQ: begin
        if (mem_flush)             state_nxt = S_IDLE;
        else if (bus.data_addr_ok) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.data_data_ok) begin
          state_nxt = mem_flush ? S_IDLE : S_DONE;
          latch     = ~mem_flush & ~wr;
        end else if (mem_flush) begin
          state_nxt = S_CANCEL;
        end
      end
      S_DONE:   if (mem_flush || !other_stall) state_nxt = S_IDLE;
      S_CANCEL: if (bus.data_data_ok) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign shifted = bus.data_rdata >> {mem_addr[1:0], 3'b000};

  always_comb begin
    load_val = shifted;
    case (size)
      2'd0:    load_val = {{24{mem_loadX & shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = {{16{mem_loadX & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      mem_rdata <= 32'h0;
    else if (latch) mem_rdata <= load_val;
  end
endmodule
